// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op encodings, FSM states and iteration bound for the multiply/divide unit
package mdu_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

    localparam logic [5:0] ITER_LAST = 6'd31;

    function automatic logic op_is_signed(input logic [1:0] op);
        return op[0];
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mult_div_32_if.sv
// rtl/mult_div_32_if.sv - request/result bundle between the datapath and the multiply/divide unit
interface mult_div_32_if;
    import mdu_pkg::*;

    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] num1;
    logic [XLEN-1:0] num2;
    logic            hi_we;
    logic            lo_we;
    logic            busy;
    logic            done;
    logic            div_zero;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output start, op, num1, num2, hi_we, lo_we,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, num1, num2, hi_we, lo_we,
        output busy, done, div_zero, hi, lo
    );

endinterface

// File: rtl/abs_neg_32.sv
// rtl/abs_neg_32.sv - combinational conditional two's-complement negate
module abs_neg_32
    import mdu_pkg::*;
(
    input  logic [XLEN-1:0] a_i,
    input  logic            neg_i,
    output logic [XLEN-1:0] y_o
);

    assign y_o = neg_i ? (~a_i + {{(XLEN-1){1'b0}}, 1'b1}) : a_i;

endmodule

// File: rtl/mult_div_32.sv
// rtl/mult_div_32.sv - iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO pair
module mult_div_32
    import mdu_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic          clk,
    input  logic          rst_n,
    mult_div_32_if.slave  bus
);

    mdu_state_e           state_q, state_d;
    logic [5:0]           cnt_q, cnt_d;
    logic [1:0]           op_q, op_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     dvsr_q, dvsr_d;
    logic [WIDTH-1:0]     num1_q, num1_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 dz_q, dz_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 div_zero_q, div_zero_d;

    logic [WIDTH-1:0]     mag1, mag2;
    logic [WIDTH-1:0]     fix_lo, fix_hi;
    logic [WIDTH-1:0]     prod_hi;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH+1:0]     div_diff;
    logic [2*WIDTH-1:0]   div_next;

    abs_neg_32 u_abs_num1 (
        .a_i   (bus.num1),
        .neg_i (op_is_signed(bus.op) & bus.num1[WIDTH-1]),
        .y_o   (mag1)
    );

    abs_neg_32 u_abs_num2 (
        .a_i   (bus.num2),
        .neg_i (op_is_signed(bus.op) & bus.num2[WIDTH-1]),
        .y_o   (mag2)
    );

    abs_neg_32 u_fix_lo (
        .a_i   (acc_q[WIDTH-1:0]),
        .neg_i (neg_res_q),
        .y_o   (fix_lo)
    );

    abs_neg_32 u_fix_hi (
        .a_i   (acc_q[2*WIDTH-1:WIDTH]),
        .neg_i (op_is_div(op_q) ? neg_rem_q : neg_res_q),
        .y_o   (fix_hi)
    );

    // 64-bit negate: the upper word only takes the +1 carry when the lower word is zero
    assign prod_hi = (neg_res_q && (acc_q[WIDTH-1:0] != '0)) ? ~acc_q[2*WIDTH-1:WIDTH] : fix_hi;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dvsr_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend/quotient bits}, shifted left each step
    assign div_diff = {1'b0, acc_q[2*WIDTH-1:WIDTH-1]} - {2'b00, dvsr_q};
    assign div_next = div_diff[WIDTH+1] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                        : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        acc_d      = acc_q;
        dvsr_d     = dvsr_q;
        num1_d     = num1_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        dz_d       = dz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = CALC;
                    cnt_d      = '0;
                    op_d       = bus.op;
                    acc_d      = {{WIDTH{1'b0}}, mag1};
                    dvsr_d     = mag2;
                    num1_d     = bus.num1;
                    neg_res_d  = op_is_signed(bus.op) & (bus.num1[WIDTH-1] ^ bus.num2[WIDTH-1]);
                    neg_rem_d  = (bus.op == OP_DIV) & bus.num1[WIDTH-1];
                    dz_d       = (bus.num2 == '0);
                    div_zero_d = 1'b0;
                end else begin
                    if (bus.hi_we) hi_d = bus.num1;
                    if (bus.lo_we) lo_d = bus.num1;
                end
            end
            CALC: begin
                acc_d = op_is_div(op_q) ? div_next : mul_next;
                if (cnt_q == ITER_LAST) state_d = FIX;
                else                    cnt_d   = cnt_q + 6'd1;
            end
            FIX: begin
                if (op_is_div(op_q)) begin
                    if (dz_q) begin
                        hi_d       = num1_q;
                        lo_d       = '1;
                        div_zero_d = 1'b1;
                    end else begin
                        hi_d = fix_hi;
                        lo_d = fix_lo;
                    end
                end else begin
                    hi_d = prod_hi;
                    lo_d = fix_lo;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= OP_MULTU;
            acc_q      <= '0;
            dvsr_q     <= '0;
            num1_q     <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            acc_q      <= acc_d;
            dvsr_q     <= dvsr_d;
            num1_q     <= num1_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            dz_q       <= dz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mult_div_32.sv
// tb/tb_mult_div_32.sv - directed self-checking bench for mult_div_32
module tb_mult_div_32;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   lat;
    int   dones;
    logic dz_acc;
    bit   moved;

    mult_div_32_if bus ();

    mult_div_32 #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_cycles(input int n, output int nd);
        nd = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
    endtask

    task automatic wait_done(output int l);
        int n;
        n = 1;
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        l = bus.done ? n : -1;
    endtask

    // inj_kind 0: extra start (DIVU 9/3) at cycle inj_at; 1: lo_we with inj_val
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit b2b, input int inj_at, input int inj_kind,
                          input logic [31:0] inj_val, input logic [31:0] prev_lo,
                          output int l, output logic dz0, output bit lo_moved);
        int  n;
        bit  seen;
        if (!b2b) @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.num1 = a; bus.num2 = b;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_after_accept", {31'd0, bus.busy}, 32'd1);
        dz0 = bus.div_zero;
        n = 1; seen = 0; lo_moved = 0;
        while (!seen && n < 40) begin
            if (n == inj_at) begin
                if (inj_kind == 0) begin
                    bus.start = 1'b1; bus.op = OP_DIVU; bus.num1 = 32'd9; bus.num2 = 32'd3;
                end else begin
                    bus.lo_we = 1'b1; bus.num1 = inj_val;
                end
            end
            @(negedge clk);
            bus.start = 1'b0; bus.lo_we = 1'b0;
            n++;
            if (bus.done) seen = 1;
            else if (bus.lo !== prev_lo) lo_moved = 1;
        end
        l = seen ? n : -1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0; bus.op = OP_MULTU; bus.num1 = '0; bus.num2 = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy",     {31'd0, bus.busy},     32'd0);
        chk("rst_done",     {31'd0, bus.done},     32'd0);
        chk("rst_div_zero", {31'd0, bus.div_zero}, 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        rst_n = 1'b1;

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, -1, 0, 0, 32'd0, lat, dz_acc, moved);
        chk("multu_latency", lat, 34);
        chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
        chk("multu_lo", bus.lo, 32'h0000_0001);
        chk("multu_busy_at_done", {31'd0, bus.busy}, 32'd0);
        chk("multu_lo_stable_calc", {31'd0, moved}, 32'd0);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, bus.done}, 32'd0);

        run_op(OP_MULT, 32'hFFFF_FFF9, 32'd3, 0, -1, 0, 0, 32'h0000_0001, lat, dz_acc, moved);
        chk("mult_latency", lat, 34);
        chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
        chk("mult_lo", bus.lo, 32'hFFFF_FFEB);

        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, -1, 0, 0, 32'hFFFF_FFEB, lat, dz_acc, moved);
        chk("div_latency", lat, 34);
        chk("div_quot", bus.lo, 32'hFFFF_FFFD);
        chk("div_rem",  bus.hi, 32'hFFFF_FFFF);

        run_op(OP_DIVU, 32'd100, 32'd0, 0, -1, 0, 0, 32'hFFFF_FFFD, lat, dz_acc, moved);
        chk("dz_latency", lat, 34);
        chk("dz_flag", {31'd0, bus.div_zero}, 32'd1);
        chk("dz_hi", bus.hi, 32'd100);
        chk("dz_lo", bus.lo, 32'hFFFF_FFFF);

        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, -1, 0, 0, 32'hFFFF_FFFF, lat, dz_acc, moved);
        chk("dz_cleared_on_start", {31'd0, dz_acc}, 32'd0);
        chk("b2b_latency", lat, 34);
        chk("ovf_lo", bus.lo, 32'h8000_0000);
        chk("ovf_hi", bus.hi, 32'd0);
        chk("ovf_div_zero", {31'd0, bus.div_zero}, 32'd0);

        run_op(OP_MULTU, 32'd1000, 32'd1000, 0, 10, 0, 0, 32'h8000_0000, lat, dz_acc, moved);
        chk("busy_start_latency", lat, 34);
        chk("busy_start_lo", bus.lo, 32'h000F_4240);
        chk("busy_start_hi", bus.hi, 32'd0);
        idle_cycles(40, dones);
        chk("busy_start_no_2nd_done", dones, 0);
        chk("busy_start_lo_kept", bus.lo, 32'h000F_4240);

        run_op(OP_MULTU, 32'd6, 32'd7, 0, 5, 1, 32'hDEAD_BEEF, 32'h000F_4240, lat, dz_acc, moved);
        chk("lo_we_busy_ignored", {31'd0, moved}, 32'd0);
        chk("lo_we_busy_result", bus.lo, 32'd42);

        @(negedge clk); bus.lo_we = 1'b1; bus.num1 = 32'h1234_5678;
        @(negedge clk); bus.lo_we = 1'b0;
        chk("mtlo_lo", bus.lo, 32'h1234_5678);
        chk("mtlo_hi_kept", bus.hi, 32'd0);
        bus.hi_we = 1'b1; bus.num1 = 32'hCAFE_F00D;
        @(negedge clk); bus.hi_we = 1'b0;
        chk("mthi_hi", bus.hi, 32'hCAFE_F00D);
        chk("mthi_lo_kept", bus.lo, 32'h1234_5678);
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.num1 = 32'h0A0B_0C0D;
        @(negedge clk); bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        chk("both_we_hi", bus.hi, 32'h0A0B_0C0D);
        chk("both_we_lo", bus.lo, 32'h0A0B_0C0D);

        bus.start = 1'b1; bus.op = OP_MULTU; bus.num1 = 32'h0001_0001; bus.num2 = 32'h0003_0000;
        bus.hi_we = 1'b1; bus.lo_we = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        chk("start_we_busy", {31'd0, bus.busy}, 32'd1);
        chk("start_we_hi_kept", bus.hi, 32'h0A0B_0C0D);
        chk("start_we_lo_kept", bus.lo, 32'h0A0B_0C0D);
        wait_done(lat);
        chk("start_we_latency", lat, 34);
        chk("start_we_prod_hi", bus.hi, 32'h0000_0003);
        chk("start_we_prod_lo", bus.lo, 32'h0003_0000);

        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_DIVU; bus.num1 = 32'hFFFF_FFFF; bus.num2 = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        chk("abort_hi", bus.hi, 32'd0);
        chk("abort_lo", bus.lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(40, dones);
        chk("abort_no_done", dones, 0);
        chk("abort_idle_busy", {31'd0, bus.busy}, 32'd0);

        run_op(OP_MULTU, 32'd6, 32'd7, 0, -1, 0, 0, 32'd0, lat, dz_acc, moved);
        chk("post_rst_latency", lat, 34);
        chk("post_rst_lo", bus.lo, 32'd42);
        chk("post_rst_hi", bus.hi, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_div_32.md
# mult_div_32

Iterative 32-bit multiply/divide unit for the CPU datapath. It sits beside the combinational bitwise/arithmetic ALU slices and owns the HI/LO register pair. It accepts one operation on a start pulse, computes it over a fixed number of cycles, and signals completion with a one-cycle done pulse. Supported operations are MULT, MULTU, DIV and DIVU.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width. Only 32 is supported; the parameter is for the bench's reference model.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  request pulse; sampled only while busy=0
- op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- num1  input  32  multiplicand / dividend
- num2  input  32  multiplier / divisor
- hi_we  input  1  direct write of HI from num1 (MTHI); honoured only when idle and start=0
- lo_we  input  1  direct write of LO from num1 (MTLO); same rule as hi_we
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; HI/LO hold the new result
- div_zero  output  1  set with done when a DIV/DIVU had num2=0; cleared on the next accepted start
- hi  output  32  HI register
- lo  output  32  LO register

## Operation
- States: IDLE, CALC, FIX.
- IDLE, start=1:
  - latch op, operand magnitudes (two's-complement absolute value for MULT/DIV) and the result sign bits;
  - clear the 6-bit iteration counter;
  - go to CALC.
- CALC runs 32 iterations, one per cycle:
  - Multiply: shift-add over a 64-bit accumulator.
  - Divide: restoring shift-subtract producing a 32-bit quotient and remainder.
  - Counter reaches 31 → go to FIX.
- FIX, one cycle:
  - Apply sign correction.
  - Multiply: {hi,lo} = 64-bit product, negated if the operand signs differ (MULT only).
  - Divide: lo = quotient, hi = remainder. Quotient truncates toward zero, negated if the signs differ. Remainder takes the sign of the dividend.
  - Divide by zero: hi = num1 as latched, lo = 32'hFFFF_FFFF, div_zero=1. Latency is unchanged.
  - Signed overflow case (DIV 32'h8000_0000 / 32'hFFFF_FFFF): lo = 32'h8000_0000, hi = 0.
  - Then go to IDLE and pulse done.
- start while busy=1 is ignored. Inputs are not re-sampled during CALC/FIX.
- hi_we/lo_we while busy=1, or in the same cycle as an accepted start, are ignored. hi_we and lo_we together write both registers.

## Timing
- Reset values: busy=0, done=0, div_zero=0, hi=0, lo=0. State returns to IDLE and the counter is cleared.
- Reset asserted mid-operation aborts immediately. No done is issued and HI/LO return to 0.
- start is accepted at edge E0. busy=1 from E0 through E33.
- E1–E32 are the CALC iterations. E33 is FIX and writes HI/LO.
- done=1 and busy=0 in the cycle following E33. Fixed latency: 34 edges from accept to result.
- The earliest next start is accepted on the edge at which done is high, giving back-to-back throughput of one operation per 34 cycles.
- hi_we/lo_we take effect on the same edge. The new value is visible on hi/lo the next cycle.
- hi/lo are never modified during CALC. Intermediate values live in internal registers.

## Structure
- Shared package `mdu_pkg`:
  - op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV);
  - state enum (IDLE, CALC, FIX);
  - ITER_LAST=31.
- One sub-module, `abs_neg_32`: combinational conditional negate. It is used for operand magnitude on entry and for sign fix-up in FIX.
- The datapath (accumulator, partial remainder, counter) and the FSM stay in `mult_div_32`.

## Test plan
- MULTU 32'hFFFF_FFFF × 32'hFFFF_FFFF → done at edge 34; hi=32'hFFFF_FFFE, lo=32'h0000_0001.
- MULT -7 × 3 → hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB. Then DIV -7 / 2 → lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF.
- DIVU 100 / 0 → div_zero=1 with done; hi=100, lo=32'hFFFF_FFFF. The next start clears div_zero.
- DIV 32'h8000_0000 / 32'hFFFF_FFFF → lo=32'h8000_0000, hi=0, div_zero=0.
- Ignored requests:
  - start pulsed at cycle 10 of a busy operation → ignored; the first result is unchanged and only one done is issued.
  - lo_we during busy → ignored.
  - lo_we in IDLE with num1=32'h1234_5678 → lo=32'h1234_5678.
- rst_n dropped at cycle 20 of a DIVU → busy=0, hi=lo=0, no done. After release, a new MULTU 6 × 7 gives lo=42.
